// File: rtl/fpu_denorm_rshift_pkg.sv
// rtl/fpu_denorm_rshift_pkg.sv - shared widths and state encoding for the denorm right shifter
package fpu_denorm_rshift_pkg;

   localparam int FPU_MANT_W  = 55;
   localparam int FPU_SHAMT_W = 12;
   localparam int FPU_STEP    = 16;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/fpu_denorm_rshift_step.sv
// rtl/fpu_denorm_rshift_step.sv - one bounded right-shift step with sticky of the bits dropped
module fpu_denorm_rshift_step
   import fpu_denorm_rshift_pkg::*;
#(
   parameter int MANT_W = FPU_MANT_W,
   parameter int STEP   = FPU_STEP,
   parameter int SW     = $clog2(STEP + 1)
) (
   input  logic [MANT_W-1:0] mant,
   input  logic [SW-1:0]     shift,
   output logic [MANT_W-1:0] mant_shifted,
   output logic              sticky
);

   logic [MANT_W-1:0] drop_mask;

   // Shifts at or beyond the width drop everything, so the mask becomes all ones.
   always_comb begin
      drop_mask    = ~({MANT_W{1'b1}} << shift);
      mant_shifted = mant >> shift;
      sticky       = |(mant & drop_mask);
   end

endmodule

// File: rtl/fpu_denorm_rshift.sv
// rtl/fpu_denorm_rshift.sv - multi-cycle denormalizing right shifter with sticky, nz and denorm flags
module fpu_denorm_rshift
   import fpu_denorm_rshift_pkg::*;
#(
   parameter int MANT_W  = FPU_MANT_W,
   parameter int SHAMT_W = FPU_SHAMT_W,
   parameter int STEP    = FPU_STEP
) (
   input  logic               rclk,
   input  logic               reset,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [MANT_W-1:0]  in_mant,
   input  logic [SHAMT_W-1:0] in_shamt,
   output logic               out_vld,
   input  logic               out_ack,
   output logic [MANT_W-1:0]  out_mant,
   output logic               out_sticky,
   output logic               out_nz,
   output logic               out_denorm
);

   localparam int RW = $clog2(MANT_W + 2);
   localparam int SW = $clog2(STEP + 1);
   localparam logic [SHAMT_W-1:0] EFF_MAX = SHAMT_W'(MANT_W + 1);

   logic [1:0]        state;
   logic [MANT_W-1:0] mant_q;
   logic              sticky_q;
   logic [RW-1:0]     remaining;
   logic              eff_nz;
   logic              out_eff_nz;

   logic [RW-1:0]     eff;
   logic [SW-1:0]     step_sh;
   logic [RW-1:0]     rem_next;
   logic [MANT_W-1:0] step_mant;
   logic              step_sticky;

   // Anything past MANT_W+1 behaves identically, so saturate to keep the counter narrow.
   always_comb begin
      eff = (in_shamt > EFF_MAX) ? RW'(MANT_W + 1) : RW'(in_shamt);
      step_sh = (32'(remaining) > STEP) ? SW'(STEP) : SW'(remaining);
      rem_next = remaining - RW'(step_sh);
   end

   fpu_denorm_rshift_step #(
      .MANT_W (MANT_W),
      .STEP   (STEP),
      .SW     (SW)
   ) u_step (
      .mant         (mant_q),
      .shift        (step_sh),
      .mant_shifted (step_mant),
      .sticky       (step_sticky)
   );

   always_ff @(posedge rclk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         mant_q     <= '0;
         sticky_q   <= 1'b0;
         remaining  <= '0;
         eff_nz     <= 1'b0;
         out_mant   <= '0;
         out_sticky <= 1'b0;
         out_eff_nz <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_vld) begin
                  mant_q    <= in_mant;
                  sticky_q  <= 1'b0;
                  remaining <= eff;
                  eff_nz    <= (eff != '0);
                  if (eff == '0) begin
                     out_mant   <= in_mant;
                     out_sticky <= 1'b0;
                     out_eff_nz <= 1'b0;
                     state      <= ST_DONE;
                  end else begin
                     state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               mant_q    <= step_mant;
               sticky_q  <= sticky_q | step_sticky;
               remaining <= rem_next;
               // Results land in separate output registers so they persist past the ack.
               if (rem_next == '0) begin
                  out_mant   <= step_mant;
                  out_sticky <= sticky_q | step_sticky;
                  out_eff_nz <= eff_nz;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ack) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_rdy     = (state == ST_IDLE);
   assign out_vld    = (state == ST_DONE);
   assign out_nz     = (|out_mant) | out_sticky;
   assign out_denorm = out_eff_nz & out_nz;

endmodule

// File: tb/tb_fpu_denorm_rshift.sv
// tb/tb_fpu_denorm_rshift.sv - directed vector bench for the denorm right shifter
module tb_fpu_denorm_rshift;

   logic        rclk;
   logic        reset;
   logic        in_vld;
   logic        in_rdy;
   logic [54:0] in_mant;
   logic [11:0] in_shamt;
   logic        out_vld;
   logic        out_ack;
   logic [54:0] out_mant;
   logic        out_sticky;
   logic        out_nz;
   logic        out_denorm;

   int n_vec;
   int n_err;

   fpu_denorm_rshift dut (
      .rclk       (rclk),
      .reset      (reset),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_mant    (in_mant),
      .in_shamt   (in_shamt),
      .out_vld    (out_vld),
      .out_ack    (out_ack),
      .out_mant   (out_mant),
      .out_sticky (out_sticky),
      .out_nz     (out_nz),
      .out_denorm (out_denorm)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic request(input logic [54:0] m, input logic [11:0] sh);
      @(negedge rclk);
      in_vld   = 1'b1;
      in_mant  = m;
      in_shamt = sh;
      @(posedge rclk);
      #1;
      in_vld   = 1'b0;
   endtask

   // Returns the cycle count from the accept edge until out_vld is seen (0 on timeout).
   task automatic wait_result(output int lat);
      int cnt;
      cnt = 1;
      while (!out_vld && cnt < 20) begin
         @(posedge rclk);
         #1;
         cnt++;
      end
      lat = out_vld ? cnt : 0;
   endtask

   task automatic ack_result(input string tag);
      @(negedge rclk);
      out_ack = 1'b1;
      check({tag, "_rdy_in_ack"}, 64'(in_rdy), 64'd0);
      @(posedge rclk);
      #1;
      out_ack = 1'b0;
      check({tag, "_vld_after_ack"}, 64'(out_vld), 64'd0);
      check({tag, "_rdy_after_ack"}, 64'(in_rdy), 64'd1);
   endtask

   task automatic run_vec(input string tag, input logic [54:0] m, input logic [11:0] sh,
                          input logic [54:0] e_mant, input logic e_sticky, input logic e_nz,
                          input logic e_den, input int e_lat);
      int lat;
      check({tag, "_rdy_before"}, 64'(in_rdy), 64'd1);
      request(m, sh);
      wait_result(lat);
      check({tag, "_latency"}, 64'(lat), 64'(e_lat));
      check({tag, "_mant"}, 64'(out_mant), 64'(e_mant));
      check({tag, "_sticky"}, 64'(out_sticky), 64'(e_sticky));
      check({tag, "_nz"}, 64'(out_nz), 64'(e_nz));
      check({tag, "_denorm"}, 64'(out_denorm), 64'(e_den));
      ack_result(tag);
   endtask

   initial begin
      int lat;
      n_vec    = 0;
      n_err    = 0;
      reset    = 1'b1;
      in_vld   = 1'b0;
      in_mant  = '0;
      in_shamt = '0;
      out_ack  = 1'b0;
      #12;
      check("rst_rdy", 64'(in_rdy), 64'd1);
      check("rst_vld", 64'(out_vld), 64'd0);
      check("rst_mant", 64'(out_mant), 64'd0);
      check("rst_sticky", 64'(out_sticky), 64'd0);
      check("rst_nz", 64'(out_nz), 64'd0);
      check("rst_denorm", 64'(out_denorm), 64'd0);
      @(negedge rclk);
      reset = 1'b0;

      run_vec("sh1",   55'h40000000000001, 12'd1,   55'h20000000000000, 1'b1, 1'b1, 1'b1, 2);
      run_vec("sh0",   55'h40000000000001, 12'd0,   55'h40000000000001, 1'b0, 1'b1, 1'b0, 1);
      run_vec("sat",   55'h40000000000001, 12'd100, 55'h0,              1'b1, 1'b1, 1'b1, 5);
      run_vec("sh56",  55'h40000000000001, 12'd56,  55'h0,              1'b1, 1'b1, 1'b1, 5);
      run_vec("sh55",  55'h40000000000001, 12'd55,  55'h0,              1'b1, 1'b1, 1'b1, 5);
      run_vec("sh20",  55'h7FFFFFFFFFFFFF, 12'd20,  55'h7FFFFFFFF,      1'b1, 1'b1, 1'b1, 3);
      run_vec("sh16",  55'h40000000000001, 12'd16,  55'h4000000000,     1'b1, 1'b1, 1'b1, 2);
      run_vec("sh17",  55'h40000000000001, 12'd17,  55'h2000000000,     1'b1, 1'b1, 1'b1, 3);
      run_vec("clean", 55'h40000000000000, 12'd3,   55'h8000000000000,  1'b0, 1'b1, 1'b1, 2);

      // Zero mantissa held under backpressure.
      request(55'h0, 12'd5);
      wait_result(lat);
      check("bp_latency", 64'(lat), 64'd2);
      for (int i = 0; i < 10; i++) begin
         @(posedge rclk);
         #1;
         check("bp_vld", 64'(out_vld), 64'd1);
         check("bp_rdy", 64'(in_rdy), 64'd0);
         check("bp_mant", 64'(out_mant), 64'd0);
         check("bp_sticky", 64'(out_sticky), 64'd0);
         check("bp_nz", 64'(out_nz), 64'd0);
         check("bp_denorm", 64'(out_denorm), 64'd0);
      end
      ack_result("bp");

      // Abort mid-shift, then a normal request afterwards.
      request(55'h40000000000001, 12'd56);
      @(posedge rclk);
      #1;
      check("abort_in_shift_rdy", 64'(in_rdy), 64'd0);
      @(negedge rclk);
      reset = 1'b1;
      #1;
      check("abort_vld", 64'(out_vld), 64'd0);
      check("abort_rdy", 64'(in_rdy), 64'd1);
      check("abort_mant", 64'(out_mant), 64'd0);
      @(negedge rclk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge rclk);
         #1;
         check("abort_no_result", 64'(out_vld), 64'd0);
      end
      run_vec("post", 55'h40000000000001, 12'd1, 55'h20000000000000, 1'b1, 1'b1, 1'b1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
